ysyx_22040632_divctrl: RTL

Issue/sequencing controller between the EXU and the shared iterative divider. It accepts one RV64M divide/remainder request at a time and short-circuits divide-by-zero and signed-overflow cases without using the divider. All other requests are issued to the divider over its handshake. The result (quotient or remainder, sign-extended for W ops) is held until the EXU accepts it, and pipeline flushes cancel any in-flight work.

---
 rtl/ysyx_22040632_divctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22040632_divctrl.sv
// Issue/sequencing controller between the EXU and the shared iterative divider.
// It accepts one RV64M div/divu/rem/remu request (optionally the W variant) at a
// time. Divide-by-zero and signed overflow are answered locally. Every other
// request is handed to the divider over a valid/ready handshake. The result is
// held until the EXU consumes it, and a flush cancels any in-flight operation.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (op, word, src1, src2)
//   flush                         cancel current operation
//   resp_valid/resp_ready         result handshake, resp_data carries the result
//   div_valid/div_ready           divider issue handshake
//   div_dividend/div_divisor      latched operands to the divider
//   div_signed/div_divw           divider mode
//   div_flush                     cancels the divider (ISSUE/BUSY flush only)
//   div_out_valid                 divider result strobe (quotient/remainder)
module ysyx_22040632_divctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_valid,
  output logic            div_divw,
  output logic            div_signed,
  output logic            div_flush,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic            is_rem_q, is_rem_d;
  logic            signed_q, signed_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            div_by_zero;
  logic            sign_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] div_res;

  // W ops return the low word sign-extended, including divuw/remuw.
  function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign req_ready = (state_q == StIdle) && !flush;
  assign accept    = req_valid && req_ready;

  // Special cases are judged on the incoming request so they resolve in the
  // accept cycle; W ops look at the low word only.
  always_comb begin
    div_by_zero = req_word ? (req_src2[31:0] == 32'd0) : (req_src2 == '0);
    sign_ovf    = !req_op[0] &&
                  (req_word ? ((req_src1[31:0] == 32'h8000_0000) && (&req_src2[31:0]))
                            : ((req_src1 == MinVal) && (&req_src2)));
    if (div_by_zero) begin
      special_res = req_op[1] ? req_src1 : '1;
    end else begin
      special_res = req_op[1] ? '0 : req_src1;
    end
  end

  assign div_res = fmt_res(is_rem_q ? div_remainder : div_quotient, word_q);

  always_comb begin
    state_d  = state_q;
    is_rem_d = is_rem_q;
    signed_d = signed_q;
    word_d   = word_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    if (flush && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            is_rem_d = req_op[1];
            signed_d = !req_op[0];
            word_d   = req_word;
            src1_d   = req_src1;
            src2_d   = req_src2;
            if (div_by_zero || sign_ovf) begin
              result_d = fmt_res(special_res, req_word);
              state_d  = StDone;
            end else begin
              state_d = StIssue;
            end
          end
        end
        StIssue: begin
          if (div_ready) state_d = StBusy;
        end
        StBusy: begin
          if (div_out_valid) begin
            result_d = div_res;
            state_d  = StDone;
          end
        end
        StDone: begin
          if (resp_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      is_rem_q <= 1'b0;
      signed_q <= 1'b0;
      word_q   <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      is_rem_q <= is_rem_d;
      signed_q <= signed_d;
      word_q   <= word_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
    end
  end

  assign resp_valid   = (state_q == StDone);
  assign resp_data    = result_q;
  assign div_valid    = (state_q == StIssue);
  assign div_flush    = flush && ((state_q == StIssue) || (state_q == StBusy));
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;
  assign div_signed   = signed_q;
  assign div_divw     = word_q;

endmodule
